song_rom: RTL and testbench



---
 rtl/song_rom.sv | 73 +++++++
 tb/tb_song_rom.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/song_rom.sv
// Lightshow script ROM for the light-stick player: 16 songs of keyframe records.
// Reads are combinational by default; with OUT_REG=1 the word is registered on clock_play.
module song_rom #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 6,
    parameter bit OUT_REG = 1'b0
) (
    input  logic              clock_play,
    input  logic              restart,
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data
);

    logic [3:0]        song;
    logic [9:0]        offset;
    logic [DATA_W-1:0] rom_word;
    logic [DATA_W-1:0] data_q;

    assign song   = address[13:10];
    assign offset = address[9:0];

    // Song 0 holds the demo show; every other song is just a terminator record.
    always_comb begin
        rom_word = 6'o00;
        if (address[15:14] == 2'b00) begin
            if (song == 4'd0) begin
                case (offset)
                    10'h000: rom_word = 6'o00;
                    10'h001: rom_word = 6'o00;
                    10'h002: rom_word = 6'o01;
                    10'h003: rom_word = 6'o63;
                    10'h004: rom_word = 6'o00;
                    10'h005: rom_word = 6'o40;
                    10'h006: rom_word = 6'o01;
                    10'h007: rom_word = 6'o60;
                    10'h008: rom_word = 6'o01;
                    10'h009: rom_word = 6'o00;
                    10'h00A: rom_word = 6'o01;
                    10'h00B: rom_word = 6'o14;
                    10'h00C: rom_word = 6'o02;
                    10'h00D: rom_word = 6'o00;
                    10'h00E: rom_word = 6'o01;
                    10'h00F: rom_word = 6'o03;
                    10'h010: rom_word = 6'o77;
                    10'h011: rom_word = 6'o77;
                    10'h012: rom_word = 6'o01;
                    10'h013: rom_word = 6'o00;
                    default: rom_word = 6'o00;
                endcase
            end else begin
                case (offset)
                    10'h000: rom_word = 6'o77;
                    10'h001: rom_word = 6'o77;
                    10'h002: rom_word = 6'o01;
                    10'h003: rom_word = 6'o00;
                    default: rom_word = 6'o00;
                endcase
            end
        end
    end

    // The register always exists; with OUT_REG=0 it is unobserved and trims away.
    always_ff @(posedge clock_play or negedge restart) begin
        if (!restart) begin
            data_q <= '0;
        end else begin
            data_q <= rom_word;
        end
    end

    assign data = OUT_REG ? data_q : rom_word;

endmodule

// File: tb/tb_song_rom.sv
// Scoreboard bench for song_rom: one combinational and one registered instance.
module tb_song_rom;

    typedef struct {
        string      label;
        bit         use_reg;
        logic [5:0] expected;
    } sb_entry_t;

    logic        clock_play;
    logic        restart;
    logic [15:0] address_c;
    logic [15:0] address_r;
    logic [5:0]  data_c;
    logic [5:0]  data_r;

    sb_entry_t   sb_queue[$];
    int          tests_run;
    int          tests_failed;

    logic [5:0]  sweep_exp [20] = '{6'o00, 6'o00, 6'o01, 6'o63, 6'o00, 6'o40, 6'o01, 6'o60,
                                    6'o01, 6'o00, 6'o01, 6'o14, 6'o02, 6'o00, 6'o01, 6'o03,
                                    6'o77, 6'o77, 6'o01, 6'o00};
    logic [15:0] walk_exp [5]  = '{16'h0000, 16'h0004, 16'h0008, 16'h000C, 16'h0010};

    song_rom #(.ADDR_W(16), .DATA_W(6), .OUT_REG(1'b0)) u_comb (
        .clock_play (clock_play),
        .restart    (restart),
        .address    (address_c),
        .data       (data_c)
    );

    song_rom #(.ADDR_W(16), .DATA_W(6), .OUT_REG(1'b1)) u_reg (
        .clock_play (clock_play),
        .restart    (restart),
        .address    (address_r),
        .data       (data_r)
    );

    initial begin
        clock_play = 1'b0;
        forever #5 clock_play = ~clock_play;
    end

    task automatic checkOutput(input string label, input logic [15:0] actual, input logic [15:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", label, actual, expected);
        end
    endtask

    task automatic pushExpect(input string label, input bit use_reg, input logic [5:0] expected);
        sb_entry_t e;
        e.label    = label;
        e.use_reg  = use_reg;
        e.expected = expected;
        sb_queue.push_back(e);
    endtask

    // Combinational lookup: drive just after a rising edge, checked at the next falling edge.
    task automatic applyStimulus(input string label, input logic [15:0] addr, input logic [5:0] expected);
        @(posedge clock_play);
        #1;
        address_c = addr;
        pushExpect(label, 1'b0, expected);
    endtask

    // Monitor: compares everything queued since the last falling edge.
    always @(negedge clock_play) begin
        while (sb_queue.size() > 0) begin
            sb_entry_t e;
            e = sb_queue.pop_front();
            checkOutput(e.label, {10'd0, (e.use_reg ? data_r : data_c)}, {10'd0, e.expected});
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] cur;
        logic [5:0]  msb;
        logic [5:0]  lsb;
        tests_run    = 0;
        tests_failed = 0;
        restart      = 1'b0;
        address_c    = 16'h0000;
        address_r    = 16'h0003;

        for (int i = 0; i < 20; i++) begin
            applyStimulus($sformatf("sweep_%0h", i), 16'(i), sweep_exp[i]);
        end

        applyStimulus("song1_0", 16'h0400, 6'o77);
        applyStimulus("song1_1", 16'h0401, 6'o77);
        applyStimulus("song1_2", 16'h0402, 6'o01);
        applyStimulus("song1_3", 16'h0403, 6'o00);
        applyStimulus("song1_4", 16'h0404, 6'o00);
        applyStimulus("song15_0", 16'h3C00, 6'o77);
        applyStimulus("song15_2", 16'h3C02, 6'o01);
        applyStimulus("high_4000", 16'h4000, 6'o00);
        applyStimulus("high_ffff", 16'hFFFF, 6'o00);
        applyStimulus("high_c000", 16'hC000, 6'o00);
        applyStimulus("song0_14", 16'h0014, 6'o00);
        applyStimulus("song0_3ff", 16'h03FF, 6'o00);

        // Record walk over song 0 using the nColor field to hop between records.
        @(posedge clock_play);
        cur = 16'h0000;
        for (int r = 0; r < 5; r++) begin
            checkOutput($sformatf("walk_addr_%0d", r), cur, walk_exp[r]);
            address_c = cur;
            #1 msb = data_c;
            address_c = cur + 16'd1;
            #1 lsb = data_c;
            if (r == 4) begin
                checkOutput("walk_terminator", {4'd0, msb, lsb}, 16'h0FFF);
            end
            address_c = cur + 16'd2;
            #1 cur = cur + 16'd3 + {10'd0, data_c};
        end

        // Registered instance: held in reset while clocking.
        @(posedge clock_play);
        #1 pushExpect("reg_reset_0", 1'b1, 6'o00);
        for (int k = 0; k < 3; k++) begin
            @(posedge clock_play);
            #1 pushExpect($sformatf("reg_reset_hold_%0d", k), 1'b1, 6'o00);
        end
        restart = 1'b1;
        #1 pushExpect("reg_release_no_edge", 1'b1, 6'o00);
        @(posedge clock_play);
        #1 pushExpect("reg_first_load", 1'b1, 6'o63);
        address_r = 16'h0007;
        #1 pushExpect("reg_latency_hold", 1'b1, 6'o63);
        @(posedge clock_play);
        #1 pushExpect("reg_load_0007", 1'b1, 6'o60);

        // Asynchronous clear between edges, hold while low, then reload.
        @(posedge clock_play);
        #1 restart = 1'b0;
        #1 pushExpect("reg_async_clear", 1'b1, 6'o00);
        @(posedge clock_play);
        #1 pushExpect("reg_clear_hold", 1'b1, 6'o00);
        restart = 1'b1;
        @(posedge clock_play);
        #1 pushExpect("reg_reload", 1'b1, 6'o60);
        address_r = 16'h0010;
        @(posedge clock_play);
        #1 pushExpect("reg_load_0010", 1'b1, 6'o77);
        address_r = 16'h8003;
        @(posedge clock_play);
        #1 pushExpect("reg_load_high", 1'b1, 6'o00);

        for (int w = 0; w < 10 && sb_queue.size() > 0; w++) begin
            @(negedge clock_play);
        end
        #1;
        if (sb_queue.size() > 0) begin
            checkOutput("scoreboard_drain", 16'(sb_queue.size()), 16'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
